// File: rtl/timed_event_replayer.sv
// timed_event_replayer
//   Upstream stimulus stage for the compiled monitor. Buffers timestamped
//   events (two signed stream values plus a presence mask) in a small FIFO
//   and replays each one at its scheduled cycle as one-cycle
//   input_N / new_input_N pulses. Absent streams drive a zero value.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   en            global enable; when low every register holds
//   s_valid/s_ready, s_ts, s_mask, s_data0, s_data1
//                 load side; s_ready is not-full from the registered count
//   input_0/1, new_input_0/1
//                 registered replay outputs to the monitor
//   time_now      free-running cycle counter (wraps)
//   count         FIFO occupancy
//   late_err      sticky: some event released after its timestamp
//   idle          FIFO empty and no pulse on the outputs
module timed_event_replayer #(
    parameter int DATA_W = 64,
    parameter int TS_W   = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [TS_W-1:0]   s_ts,
    input  logic [1:0]        s_mask,
    input  logic [DATA_W-1:0] s_data0,
    input  logic [DATA_W-1:0] s_data1,
    output logic [DATA_W-1:0] input_0,
    output logic              new_input_0,
    output logic [DATA_W-1:0] input_1,
    output logic              new_input_1,
    output logic [TS_W-1:0]   time_now,
    output logic [ADDR_W:0]   count,
    output logic              late_err,
    output logic              idle
);

    localparam int DEPTH = 1 << ADDR_W;

    // FIRE is never stored: it is the phase a WAIT cycle takes on when the
    // head is due, so the pop and the output register load share one edge
    // and a head with ts=T pulses while time_now reads T+1.
    typedef enum logic [1:0] {EMPTY, WAIT, FIRE} state_t;

    state_t r_state, w_phase, w_state_nxt;

    logic [TS_W-1:0]   r_ts_mem   [DEPTH];
    logic [1:0]        r_mask_mem [DEPTH];
    logic [DATA_W-1:0] r_d0_mem   [DEPTH];
    logic [DATA_W-1:0] r_d1_mem   [DEPTH];

    logic [ADDR_W-1:0] r_wptr, r_rptr;
    logic [ADDR_W:0]   r_count;
    logic [TS_W-1:0]   r_time;
    logic [DATA_W-1:0] r_in0, r_in1;
    logic              r_new0, r_new1, r_late;

    logic              w_push, w_pop, w_fire, w_due, w_late;
    logic [TS_W-1:0]   w_diff;
    logic [1:0]        w_head_mask;

    assign s_ready     = (r_count != (ADDR_W+1)'(DEPTH));
    assign w_push      = s_valid && s_ready && en;
    assign w_pop       = w_fire && en;
    assign w_head_mask = r_mask_mem[r_rptr];

    // Signed wrap-safe compare: the head is due once time_now has reached
    // its timestamp, even across a counter wrap.
    assign w_diff = r_time - r_ts_mem[r_rptr];
    assign w_due  = ~w_diff[TS_W-1];
    assign w_late = w_due && (w_diff != '0);

    always_comb begin
        w_phase     = r_state;
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        if (r_state == WAIT && w_due) w_phase = FIRE;
        case (w_phase)
            EMPTY: if (w_push) w_state_nxt = WAIT;
            WAIT:  w_state_nxt = WAIT;
            FIRE: begin
                w_fire = 1'b1;
                // Entries left after this pop, counting a same-edge push.
                w_state_nxt = (r_count > (ADDR_W+1)'(1) || w_push) ? WAIT : EMPTY;
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Payload storage carries no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ts_mem[r_wptr]   <= s_ts;
            r_mask_mem[r_wptr] <= s_mask;
            r_d0_mem[r_wptr]   <= s_data0;
            r_d1_mem[r_wptr]   <= s_data1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_time  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_in0   <= '0;
            r_in1   <= '0;
            r_new0  <= 1'b0;
            r_new1  <= 1'b0;
            r_late  <= 1'b0;
        end else if (en) begin
            r_state <= w_state_nxt;
            r_time  <= r_time + TS_W'(1);
            if (w_push) r_wptr <= r_wptr + ADDR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + ADDR_W'(1);
            r_count <= r_count + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);
            // Pulses last exactly one enabled cycle; values are zero unless pulsing.
            r_new0  <= w_fire && w_head_mask[0];
            r_new1  <= w_fire && w_head_mask[1];
            r_in0   <= (w_fire && w_head_mask[0]) ? r_d0_mem[r_rptr] : '0;
            r_in1   <= (w_fire && w_head_mask[1]) ? r_d1_mem[r_rptr] : '0;
            if (w_fire && w_late) r_late <= 1'b1;
        end
    end

    assign input_0     = r_in0;
    assign input_1     = r_in1;
    assign new_input_0 = r_new0;
    assign new_input_1 = r_new1;
    assign time_now    = r_time;
    assign count       = r_count;
    assign late_err    = r_late;
    assign idle        = (r_count == '0) && !r_new0 && !r_new1;

endmodule

// File: tb/tb_timed_event_replayer.sv
// Directed bench for timed_event_replayer: scheduled release, full FIFO,
// equal timestamps, late push, enable hold, and mid-run reset.
module tb_timed_event_replayer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_ts = '0;
    logic [1:0]  s_mask = '0;
    logic [63:0] s_data0 = '0;
    logic [63:0] s_data1 = '0;
    logic [63:0] input_0, input_1;
    logic        new_input_0, new_input_1;
    logic [31:0] time_now;
    logic [3:0]  count;
    logic        late_err, idle;

    int checks = 0;
    int errors = 0;

    timed_event_replayer dut (
        .clk(clk), .rst(rst), .en(en),
        .s_valid(s_valid), .s_ready(s_ready), .s_ts(s_ts), .s_mask(s_mask),
        .s_data0(s_data0), .s_data1(s_data1),
        .input_0(input_0), .new_input_0(new_input_0),
        .input_1(input_1), .new_input_1(new_input_1),
        .time_now(time_now), .count(count), .late_err(late_err), .idle(idle)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time_now=%0d", time_now);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic push(input logic [31:0] ts, input logic [1:0] m,
                        input logic [63:0] d0, input logic [63:0] d1);
        s_valid = 1'b1; s_ts = ts; s_mask = m; s_data0 = d0; s_data1 = d1;
        tick(1);
        s_valid = 1'b0;
    endtask

    // Advance until time_now == t, flagging timeout and any pulse seen on the way.
    task automatic wait_time(input logic [31:0] t, input string tag);
        int   n = 0;
        logic seen = 1'b0;
        while (time_now !== t && n < 5000) begin
            tick(1);
            seen = seen | new_input_0 | new_input_1;
            n++;
        end
        chk({tag, "_reach"}, time_now, t);
        chk({tag, "_quiet"}, seen, 1'b0);
    endtask

    task automatic chk_pulse(input string tag, input logic n0, input logic [63:0] v0,
                             input logic n1, input logic [63:0] v1);
        chk({tag, "_new0"}, new_input_0, n0);
        chk({tag, "_in0"},  input_0, v0);
        chk({tag, "_new1"}, new_input_1, n1);
        chk({tag, "_in1"},  input_1, v1);
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_time", time_now, 0);
        chk("rst_count", count, 0);
        chk("rst_ready", s_ready, 1);
        chk("rst_idle", idle, 1);
        chk("rst_late", late_err, 0);
        chk_pulse("rst", 0, 0, 0, 0);
        tick(1);
        rst = 1'b0;
        chk("rst_hold_time", time_now, 0);

        // Two scheduled events
        push(1000, 2'b11, 1, 1);
        push(2000, 2'b11, 2, 2);
        chk("s1_count", count, 2);
        chk("s1_idle", idle, 0);
        wait_time(1000, "s1_a");
        tick(1);
        chk("s1_a_time", time_now, 1001);
        chk_pulse("s1_a", 1, 1, 1, 1);
        tick(1);
        chk_pulse("s1_gap", 0, 0, 0, 0);
        wait_time(2000, "s1_b");
        tick(1);
        chk_pulse("s1_b", 1, 2, 1, 2);
        tick(1);
        chk_pulse("s1_end", 0, 0, 0, 0);
        chk("s1_late", late_err, 0);
        chk("s1_idle_end", idle, 1);

        // Fill the FIFO, then attempt a ninth push
        do_reset();
        chk("s2_time0", time_now, 0);
        for (int i = 0; i < 8; i++) push(32'(100 + i), 2'b11, 64'(i), 64'(i + 16));
        chk("s2_full_count", count, 8);
        chk("s2_full_ready", s_ready, 0);
        s_valid = 1'b1; s_ts = 200; s_mask = 2'b11; s_data0 = 99; s_data1 = 99;
        tick(2);
        s_valid = 1'b0;
        chk("s2_no9th", count, 8);
        wait_time(100, "s2");
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("s2_rel_time", time_now, 32'(101 + i));
            chk_pulse("s2_rel", 1, 64'(i), 1, 64'(i + 16));
        end
        tick(1);
        chk_pulse("s2_after", 0, 0, 0, 0);
        chk("s2_empty", count, 0);
        chk("s2_late", late_err, 0);
        wait_time(220, "s2_no9th_rel");

        // Equal timestamps, plus a push on the first pop edge
        do_reset();
        push(500, 2'b11, 3, 30);
        push(500, 2'b11, 4, 40);
        wait_time(500, "s3");
        s_valid = 1'b1; s_ts = 600; s_mask = 2'b11; s_data0 = 6; s_data1 = 60;
        tick(1);
        s_valid = 1'b0;
        chk("s3_pushpop_count", count, 2);
        chk_pulse("s3_first", 1, 3, 1, 30);
        chk("s3_late_first", late_err, 0);
        tick(1);
        chk("s3_second_time", time_now, 502);
        chk_pulse("s3_second", 1, 4, 1, 40);
        chk("s3_late_second", late_err, 1);
        chk("s3_count", count, 1);
        wait_time(600, "s3_third");
        tick(1);
        chk_pulse("s3_third", 1, 6, 1, 60);

        // Late push into empty FIFO
        do_reset();
        chk("s4_late_cleared", late_err, 0);
        wait_time(50, "s4");
        push(10, 2'b01, -64'sd5, 9);
        chk_pulse("s4_wait", 0, 0, 0, 0);
        tick(1);
        chk("s4_time", time_now, 52);
        chk_pulse("s4_pulse", 1, 64'hFFFF_FFFF_FFFF_FFFB, 0, 0);
        chk("s4_late", late_err, 1);
        tick(1);
        chk_pulse("s4_after", 0, 0, 0, 0);

        // Enable hold before and during the pulse
        do_reset();
        push(300, 2'b10, 5, 7);
        wait_time(290, "s5");
        en = 1'b0;
        tick(20);
        chk("s5_hold_time", time_now, 290);
        chk("s5_hold_count", count, 1);
        chk_pulse("s5_hold", 0, 0, 0, 0);
        en = 1'b1;
        wait_time(300, "s5_run");
        tick(1);
        chk_pulse("s5_pulse", 0, 0, 1, 7);
        en = 1'b0;
        tick(3);
        chk("s5_pulse_time", time_now, 301);
        chk_pulse("s5_pulse_held", 0, 0, 1, 7);
        en = 1'b1;
        tick(1);
        chk_pulse("s5_after", 0, 0, 0, 0);
        chk("s5_late", late_err, 0);
        chk("s5_idle", idle, 1);

        // Reset mid-operation flushes pending events
        do_reset();
        push(250, 2'b11, 1, 2);
        push(260, 2'b11, 3, 4);
        push(270, 2'b11, 5, 6);
        wait_time(200, "s6");
        chk("s6_count_pre", count, 3);
        rst = 1'b1;
        #1;
        chk("s6_async_count", count, 0);
        chk("s6_async_idle", idle, 1);
        chk("s6_async_time", time_now, 0);
        chk_pulse("s6_async", 0, 0, 0, 0);
        tick(1);
        rst = 1'b0;
        wait_time(300, "s6_none");
        chk("s6_count_post", count, 0);
        chk("s6_late", late_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
